// File: rtl/asic_cfg_sr_slave.sv
// ---------------------------------------------------------------------------
// asic_cfg_sr_slave
//   Receive side of the serial configuration link (loopback model of the ASIC
//   configuration shift chain). The link is oversampled on CLK and MSB-first
//   frames are deserialised into a shift register. An 88-bit frame is
//   committed to static_conf, a 16-bit frame to dynamic_conf. Every captured
//   bit is echoed back on miso_out at the following SCLK fall so the bridge
//   can compare what it sent against what came back.
//
// Ports
//   CLK           system clock (single domain)
//   RST           synchronous, active-high reset
//   sclk_in       serial clock, idle low, data sampled on rising edge
//   mosi_in       serial data, MSB first
//   sel_in        frame select, active low
//   miso_out      loopback data (bit captured on the previous SCLK rise)
//   static_conf   last committed static configuration
//   dynamic_conf  last committed dynamic configuration
//   stat_valid    one-CLK pulse on static commit
//   dyn_valid     one-CLK pulse on dynamic commit
//   frame_err     one-CLK pulse when a frame has an illegal length
//   busy          high while a frame is being shifted in
//
// State        | meaning
// -------------+---------------------------------------------------------
// WAIT_IDLE    | after reset; wait for sel high so no partial frame lands
// IDLE         | between frames; wait for sel fall
// SHIFT        | frame open; shift on SCLK rise, echo on SCLK fall
// COMMIT       | one cycle; route the frame by its bit count
// ---------------------------------------------------------------------------
module asic_cfg_sr_slave #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int CNT_W      = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sclk_in,
    input  logic                  mosi_in,
    input  logic                  sel_in,
    output logic                  miso_out,
    output logic [SIZESRSTAT-1:0] static_conf,
    output logic [SIZESRDYN-1:0]  dynamic_conf,
    output logic                  stat_valid,
    output logic                  dyn_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] CNT_STAT = CNT_W'(SIZESRSTAT);
    localparam logic [CNT_W-1:0] CNT_DYN  = CNT_W'(SIZESRDYN);
    // Saturation value: one past a full static frame, so over-long frames
    // can never wrap back onto a legal count.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SIZESRSTAT + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    // Two-flop synchronisers, then an edge-detect register for sclk and sel.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic sel_meta_q,  sel_sync_q,  sel_prev_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            sel_meta_q  <= 1'b0;
            sel_sync_q  <= 1'b0;
            sel_prev_q  <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_in;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= mosi_in;
            mosi_sync_q <= mosi_meta_q;
            sel_meta_q  <= sel_in;
            sel_sync_q  <= sel_meta_q;
            sel_prev_q  <= sel_sync_q;
        end
    end

    logic sclk_rise, sclk_fall, sel_rise, sel_fall;

    always_comb begin
        sclk_rise = sclk_sync_q & ~sclk_prev_q;
        sclk_fall = ~sclk_sync_q & sclk_prev_q;
        sel_rise  = sel_sync_q & ~sel_prev_q;
        sel_fall  = ~sel_sync_q & sel_prev_q;
    end

    state_t                  state_q;
    logic [SIZESRSTAT-1:0]   sr_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [SIZESRSTAT-1:0]   static_q;
    logic [SIZESRDYN-1:0]    dynamic_q;
    logic                    miso_q;
    logic                    stat_valid_q;
    logic                    dyn_valid_q;
    logic                    frame_err_q;
    logic                    busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= WAIT_IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            static_q     <= '0;
            dynamic_q    <= '0;
            miso_q       <= 1'b0;
            stat_valid_q <= 1'b0;
            dyn_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            stat_valid_q <= 1'b0;
            dyn_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                WAIT_IDLE: begin
                    if (sel_sync_q) begin
                        state_q <= IDLE;
                    end
                end

                IDLE: begin
                    // An SCLK rise coincident with the sel fall is dropped.
                    if (sel_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (sel_rise) begin
                        // Frame closes; a coincident SCLK edge is ignored.
                        state_q <= COMMIT;
                        busy_q  <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            sr_q <= {sr_q[SIZESRSTAT-2:0], mosi_sync_q};
                            if (bit_cnt_q != CNT_MAX) begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            miso_q <= sr_q[0];
                        end
                    end
                end

                COMMIT: begin
                    state_q <= IDLE;
                    if (bit_cnt_q == CNT_STAT) begin
                        static_q     <= sr_q;
                        stat_valid_q <= 1'b1;
                    end else if (bit_cnt_q == CNT_DYN) begin
                        dynamic_q   <= sr_q[SIZESRDYN-1:0];
                        dyn_valid_q <= 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        // Empty frames are silent; everything else is an error.
                        frame_err_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= WAIT_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign miso_out     = miso_q;
    assign static_conf  = static_q;
    assign dynamic_conf = dynamic_q;
    assign stat_valid   = stat_valid_q;
    assign dyn_valid    = dyn_valid_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

endmodule

// File: doc/asic_cfg_sr_slave.md
Name: asic_cfg_sr_slave

Overview:
- ASIC-side receiver of the serial configuration link driven by ASIC_bridge_top. Models the ASIC configuration shift chain for FPGA-level loopback and regression.
- Oversamples the link (clk_output/mosi_output/sel_output from the bridge) on the local clock and deserialises MSB-first frames.
- Commits 88-bit frames to the static register and 16-bit frames to the dynamic register.
- Echoes every received bit back on MISO so the bridge's XOR readback check can run.

Parameters:
- SIZESRSTAT, 88, static configuration frame length / static register width.
- SIZESRDYN, 16, dynamic configuration frame length / dynamic register width; must be < SIZESRSTAT.
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W > SIZESRSTAT+1.

Ports:
- CLK  in  1  system clock, single clock domain (16 MHz nominal).
- RST  in  1  synchronous, active-high reset.
- sclk_in  in  1  serial clock from bridge; idle low; data sampled on rising edge.
- mosi_in  in  1  serial data from bridge, MSB first.
- sel_in  in  1  frame select, active low.
- miso_out  out  1  loopback serial data to bridge.
- static_conf  out  SIZESRSTAT  last committed static configuration.
- dynamic_conf  out  SIZESRDYN  last committed dynamic configuration.
- stat_valid  out  1  one-CLK pulse on static commit.
- dyn_valid  out  1  one-CLK pulse on dynamic commit.
- frame_err  out  1  one-CLK pulse on a frame with illegal length.
- busy  out  1  high while in SHIFT.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Input conditioning:
  - sclk_in, mosi_in and sel_in each pass through a 2-FF synchroniser, then one edge-detect register.
  - A rise/fall is "detected" in the cycle where synced value ≠ previous synced value.
- Link constraints (bench obeys; RTL need not check): SCLK high and low ≥ 2 CLK each; mosi stable ≥ 2 CLK around the SCLK rise; sel edges ≥ 2 CLK from any SCLK edge.
- State machine (states WAIT_IDLE, IDLE, SHIFT, COMMIT):
  - WAIT_IDLE: entered on reset. Moves to IDLE once synced sel is high. Prevents a partial frame after a mid-frame reset.
  - IDLE: on sel fall detected → SHIFT; bit_cnt ← 0.
  - SHIFT, on SCLK rise detected: sr ← {sr[SIZESRSTAT-2:0], mosi_sync}; bit_cnt increments, saturating at SIZESRSTAT+1.
  - SHIFT, on SCLK fall detected: miso_out ← sr[0], i.e. the bit captured on the previous rise.
  - SHIFT, on sel rise detected → COMMIT. An SCLK edge detected in the same cycle is ignored.
  - COMMIT (exactly 1 cycle), then → IDLE:
    - bit_cnt == SIZESRSTAT: static_conf ← sr; stat_valid = 1.
    - bit_cnt == SIZESRDYN: dynamic_conf ← sr[SIZESRDYN-1:0]; dyn_valid = 1.
    - bit_cnt == 0: no update, no pulse; an empty frame is silent.
    - any other count, including saturated: frame_err = 1, no update.
- Timing: commit outputs and pulses appear the cycle after sel rise is detected, i.e. 4 CLK after the sel_in rising edge at the pin.
- The two configuration registers are independent; each holds its value until its own legal commit.
- SCLK edges outside SHIFT are ignored.
- A sel fall in IDLE in the same cycle as an SCLK rise: the SCLK rise is not shifted.
- miso_out holds its last value between frames.
- Reset, including mid-frame, drives all of the following to 0 in the next cycle:
  - static_conf, dynamic_conf, sr, bit_cnt;
  - miso_out, busy;
  - all pulses.
  - State ← WAIT_IDLE.
- busy = (state == SHIFT).

Test Plan:
- Static frame, CLK 16 MHz, SCLK 2 MHz: send 88'hF123456789ABCDEF012F → static_conf = 88'hF123456789ABCDEF012F; stat_valid high exactly 1 CLK, 4 CLK after the sel rise; dynamic_conf stays 0.
- Dynamic frame 16'hF5AF after the static frame → dynamic_conf = 16'hF5AF, dyn_valid pulse; static_conf unchanged.
- Loopback: capture miso_out on each SCLK rise during a frame of 16'hF23F → bits 2..16 equal MOSI bits 1..15; XOR against MOSI delayed by one bit is 0.
- Illegal lengths: 20-bit frame → frame_err pulse; 89-bit frame → frame_err pulse; both registers unchanged, no valid pulses. Empty frame (sel low then high, no SCLK) → no pulses.
- Reset mid-frame: assert RST for 1 CLK after 40 bits with sel still low, then continue clocking 48 bits → all outputs 0 and no commit at sel rise. Next frame 88'hFACEB00C1234567890DF → committed correctly.
- Back-to-back frames: sel high for 4 CLK between an 88-bit and a 16-bit frame → both commit, one pulse each, busy low only in the gap.
